// File: rtl/counter_chain_ctrl_if.sv
// rtl/counter_chain_ctrl_if.sv - button pulses, digit readback and digit-counter controls for the counter chain
interface counter_chain_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      start_stop;
    logic                      dir_toggle;
    logic                      clear;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic                      count_dir;
    logic                      digit_rst;
    logic                      running;
    logic                      at_limit;

    // master: the button/digit side; slave: the controller
    modport master (
        output start_stop, dir_toggle, clear, digits_in,
        input  digit_en, count_dir, digit_rst, running, at_limit
    );

    modport slave (
        input  start_stop, dir_toggle, clear, digits_in,
        output digit_en, count_dir, digit_rst, running, at_limit
    );
endinterface

// File: rtl/counter_chain_ctrl.sv
// rtl/counter_chain_ctrl.sv - run/pause/clear sequencer, prescaler and ripple enables for cascaded digit counters
module counter_chain_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int TICK_DIV      = 100000000,
    parameter int STOP_AT_LIMIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_chain_ctrl_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t                 state, state_next;
    logic [PW-1:0]          presc, presc_next;
    logic [NUM_DIGITS-1:0]  en_q, en_next;
    logic [NUM_DIGITS-1:0]  terminal, step_mask;
    logic                   dir_q, dir_next;
    logic                   rst_q, running_q, at_limit_q;
    logic                   tick, all_terminal;

    // A digit steps only when every less significant digit is about to carry/borrow
    always_comb begin
        terminal  = '0;
        step_mask = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            terminal[i] = dir_q ? (bus.digits_in[4*i +: 4] == 4'hF)
                                : (bus.digits_in[4*i +: 4] == 4'h0);
        end
        step_mask[0] = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            step_mask[i] = step_mask[i-1] & terminal[i-1];
        end
        all_terminal = &terminal;
        tick         = (state == RUN) && (presc == PRESC_LAST);
    end

    always_comb begin
        state_next = state;
        en_next    = '0;
        presc_next = '0;
        dir_next   = bus.dir_toggle ? ~dir_q : dir_q;
        if (bus.clear) begin
            state_next = IDLE;
        end else begin
            if (tick && (STOP_AT_LIMIT != 0) && all_terminal) begin
                state_next = DONE;
            end else begin
                if (tick) begin
                    en_next = step_mask;
                end
                unique case (state)
                    IDLE:   if (bus.start_stop) state_next = RUN;
                    RUN:    if (bus.start_stop) state_next = PAUSED;
                    PAUSED: if (bus.start_stop) state_next = RUN;
                    DONE:   if (bus.dir_toggle) state_next = PAUSED;
                    default: state_next = IDLE;
                endcase
            end
            // Leaving RUN parks the prescaler so a resume waits a full period
            if (state == RUN && state_next == RUN) begin
                presc_next = tick ? '0 : presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            en_q       <= '0;
            dir_q      <= 1'b1;
            rst_q      <= 1'b1;
            running_q  <= 1'b0;
            at_limit_q <= 1'b0;
        end else begin
            state      <= state_next;
            presc      <= presc_next;
            en_q       <= en_next;
            dir_q      <= dir_next;
            rst_q      <= bus.clear;
            running_q  <= (state_next == RUN);
            at_limit_q <= (state_next == DONE);
        end
    end

    assign bus.digit_en  = en_q;
    assign bus.count_dir = dir_q;
    assign bus.digit_rst = rst_q;
    assign bus.running   = running_q;
    assign bus.at_limit  = at_limit_q;
endmodule

// File: tb/tb_counter_chain_ctrl.sv
// tb/tb_counter_chain_ctrl.sv - randomized and directed self-checking bench for counter_chain_ctrl (halting and wrapping builds)
module tb_counter_chain_ctrl;
    localparam int ND = 2;
    localparam int TD = 4;

    typedef struct {
        int       st;      // 0 idle, 1 run, 2 paused, 3 done
        int       presc;
        logic     dir;
        logic [1:0] en;
        logic     rst;
    } model_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ss = 1'b0, dt = 1'b0, cl = 1'b0;
    logic pre_en = 1'b0;
    logic [7:0] pre_val = 8'h00;
    logic [7:0] dig_s = 8'h00, dig_w = 8'h00;
    logic chk_on = 1'b0;
    int checks = 0;
    int errors = 0;
    model_t m_s, m_w;

    always #5 clk = ~clk;

    counter_chain_ctrl_if #(.NUM_DIGITS(ND)) bus_s ();
    counter_chain_ctrl_if #(.NUM_DIGITS(ND)) bus_w ();

    assign bus_s.start_stop = ss;
    assign bus_s.dir_toggle = dt;
    assign bus_s.clear      = cl;
    assign bus_s.digits_in  = dig_s;
    assign bus_w.start_stop = ss;
    assign bus_w.dir_toggle = dt;
    assign bus_w.clear      = cl;
    assign bus_w.digits_in  = dig_w;

    counter_chain_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .STOP_AT_LIMIT(1)) dut_stop (
        .clk(clk), .reset(reset), .bus(bus_s)
    );
    counter_chain_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .STOP_AT_LIMIT(0)) dut_wrap (
        .clk(clk), .reset(reset), .bus(bus_w)
    );

    function automatic logic [7:0] step_digits(logic [7:0] v, logic [1:0] en, logic dir);
        logic [7:0] r;
        logic [3:0] nib;
        r = v;
        for (int i = 0; i < ND; i++) begin
            nib = v[4*i +: 4];
            if (en[i]) nib = dir ? nib + 4'd1 : nib - 4'd1;
            r[4*i +: 4] = nib;
        end
        return r;
    endfunction

    // Digit i moves when the value below it is all-ones (up) or all-zeros (down)
    function automatic logic [1:0] expect_mask(logic [7:0] v, logic dir);
        logic [1:0] m;
        int p, low;
        m = '0;
        for (int i = 0; i < ND; i++) begin
            p   = 1 << (4 * i);
            low = int'(v) % p;
            m[i] = dir ? (low == p - 1) : (low == 0);
        end
        return m;
    endfunction

    function automatic model_t next_model(model_t c, bit stop, logic [7:0] v,
                                          logic r, logic clr, logic s, logic d);
        model_t n;
        bit tick, lim;
        n = c;
        n.en = '0;
        n.rst = 1'b0;
        if (r) begin
            n.st = 0; n.presc = 0; n.dir = 1'b1; n.rst = 1'b1;
            return n;
        end
        if (d) n.dir = ~c.dir;
        if (clr) begin
            n.st = 0; n.presc = 0; n.rst = 1'b1;
            return n;
        end
        tick = (c.st == 1) && (c.presc == TD - 1);
        lim  = tick && stop && (c.dir ? (v == 8'hFF) : (v == 8'h00));
        if (lim) begin
            n.st = 3;
        end else begin
            if (tick) n.en = expect_mask(v, c.dir);
            if (s) begin
                if (c.st == 0 || c.st == 2) n.st = 1;
                else if (c.st == 1) n.st = 2;
            end
            if (d && c.st == 3) n.st = 2;
        end
        n.presc = (c.st == 1 && n.st == 1) ? (c.presc + 1) % TD : 0;
        return n;
    endfunction

    always @(posedge clk) begin
        m_s <= next_model(m_s, 1'b1, dig_s, reset, cl, ss, dt);
        m_w <= next_model(m_w, 1'b0, dig_w, reset, cl, ss, dt);
    end

    always @(posedge clk) begin
        if (bus_s.digit_rst) dig_s <= 8'h00;
        else if (pre_en)     dig_s <= pre_val;
        else                 dig_s <= step_digits(dig_s, bus_s.digit_en, bus_s.count_dir);
        if (bus_w.digit_rst) dig_w <= 8'h00;
        else if (pre_en)     dig_w <= pre_val;
        else                 dig_w <= step_digits(dig_w, bus_w.digit_en, bus_w.count_dir);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("stop.digit_en",  32'(bus_s.digit_en),  32'(m_s.en));
            check("stop.count_dir", 32'(bus_s.count_dir), 32'(m_s.dir));
            check("stop.digit_rst", 32'(bus_s.digit_rst), 32'(m_s.rst));
            check("stop.running",   32'(bus_s.running),   32'(m_s.st == 1));
            check("stop.at_limit",  32'(bus_s.at_limit),  32'(m_s.st == 3));
            check("wrap.digit_en",  32'(bus_w.digit_en),  32'(m_w.en));
            check("wrap.count_dir", 32'(bus_w.count_dir), 32'(m_w.dir));
            check("wrap.digit_rst", 32'(bus_w.digit_rst), 32'(m_w.rst));
            check("wrap.running",   32'(bus_w.running),   32'(m_w.st == 1));
            check("wrap.at_limit",  32'(bus_w.at_limit),  32'(m_w.st == 3));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic d, input logic c);
        ss = s; dt = d; cl = c;
        wait_cyc(1);
        ss = 1'b0; dt = 1'b0; cl = 1'b0;
    endtask

    task automatic preload(input logic [7:0] v);
        pre_en = 1'b1; pre_val = v;
        wait_cyc(1);
        pre_en = 1'b0;
    endtask

    initial begin
        logic [7:0] picks [6];
        picks[0] = 8'h00; picks[1] = 8'h01; picks[2] = 8'hFE;
        picks[3] = 8'hFF; picks[4] = 8'h0F; picks[5] = 8'h10;

        // Reset and first counts
        wait_cyc(3);
        reset = 1'b0;
        chk_on = 1'b1;
        check("rst.digit_rst", 32'(bus_s.digit_rst), 32'd1);
        check("rst.count_dir", 32'(bus_s.count_dir), 32'd1);
        check("rst.running",   32'(bus_s.running),   32'd0);
        check("rst.digit_en",  32'(bus_s.digit_en),  32'd0);
        wait_cyc(1);
        check("rst.rst_pulse_end", 32'(bus_s.digit_rst), 32'd0);
        pulse(1, 0, 0);
        wait_cyc(3);
        check("t1.no_early_en", 32'(bus_s.digit_en), 32'd0);
        wait_cyc(1);
        check("t1.first_en", 32'(bus_s.digit_en), 32'h1);
        wait_cyc(1);
        check("t1.digits_01", 32'(dig_s), 32'h01);
        wait_cyc(4);
        check("t1.digits_02", 32'(dig_s), 32'h02);

        // Carry up from 0x0F, borrow down from 0x10
        pulse(1, 0, 0);
        preload(8'h0F);
        pulse(1, 0, 0);
        wait_cyc(4);
        check("t2.carry_en", 32'(bus_s.digit_en), 32'h3);
        wait_cyc(1);
        check("t2.digits_10", 32'(dig_s), 32'h10);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        wait_cyc(4);
        check("t2.borrow_en", 32'(bus_s.digit_en), 32'h3);
        wait_cyc(1);
        check("t2.digits_0f", 32'(dig_s), 32'h0F);
        pulse(1, 0, 0);

        // Limit on the halting build, wrap on the free-running one
        pulse(0, 1, 0);
        preload(8'hFE);
        pulse(1, 0, 0);
        wait_cyc(5);
        check("t3.digits_ff", 32'(dig_s), 32'hFF);
        wait_cyc(3);
        check("t3.at_limit", 32'(bus_s.at_limit), 32'd1);
        check("t3.running",  32'(bus_s.running),  32'd0);
        check("t3.no_en",    32'(bus_s.digit_en), 32'd0);
        check("t4.wrap_en",  32'(bus_w.digit_en), 32'h3);
        check("t4.no_limit", 32'(bus_w.at_limit), 32'd0);
        wait_cyc(1);
        check("t4.digits_00", 32'(dig_w), 32'h00);
        check("t3.held_ff",   32'(dig_s), 32'hFF);
        pulse(1, 0, 0);
        check("t3.ss_ignored", 32'(bus_s.at_limit), 32'd1);
        pulse(0, 1, 0);
        check("t3.left_done", 32'(bus_s.at_limit),  32'd0);
        check("t3.paused",    32'(bus_s.running),   32'd0);
        check("t3.dir_down",  32'(bus_s.count_dir), 32'd0);
        pulse(1, 0, 0);
        wait_cyc(5);
        check("t3.digits_fe", 32'(dig_s), 32'hFE);
        check("t4.digits_ff", 32'(dig_w), 32'hFF);

        // clear with start_stop lands on a tick cycle and aborts it
        wait_cyc(2);
        pulse(1, 0, 1);
        check("t5.running",   32'(bus_s.running),   32'd0);
        check("t5.digit_rst", 32'(bus_s.digit_rst), 32'd1);
        check("t5.no_en",     32'(bus_s.digit_en),  32'd0);
        wait_cyc(1);
        check("t5.digits_00", 32'(dig_s), 32'h00);
        check("t5.rst_end",   32'(bus_s.digit_rst), 32'd0);
        wait_cyc(6);
        check("t5.still_idle", 32'(bus_s.running), 32'd0);

        // Pause mid-period, resume waits a full period, then reset mid-run
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        wait_cyc(1);
        pulse(1, 0, 0);
        wait_cyc(5);
        check("t6.paused_no_en", 32'(bus_s.digit_en), 32'd0);
        pulse(1, 0, 0);
        wait_cyc(3);
        check("t6.resume_early", 32'(bus_s.digit_en), 32'd0);
        wait_cyc(1);
        check("t6.resume_en", 32'(bus_s.digit_en), 32'h1);
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check("t6.rst_digit_rst", 32'(bus_s.digit_rst), 32'd1);
        check("t6.rst_dir",       32'(bus_s.count_dir), 32'd1);
        check("t6.rst_running",   32'(bus_s.running),   32'd0);
        check("t6.rst_limit",     32'(bus_s.at_limit),  32'd0);
        check("t6.rst_en",        32'(bus_s.digit_en),  32'd0);

        // Randomized pulses, preloads and resets against the model
        for (int n = 0; n < 4000; n++) begin
            ss = ($urandom_range(0, 9) == 0);
            dt = ($urandom_range(0, 15) == 0);
            cl = ($urandom_range(0, 59) == 0);
            if (cl) dt = 1'b0;
            reset = ($urandom_range(0, 299) == 0);
            pre_en = ($urandom_range(0, 24) == 0);
            pre_val = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 5)]
                                                  : 8'($urandom_range(0, 255));
            wait_cyc(1);
        end
        ss = 1'b0; dt = 1'b0; cl = 1'b0; reset = 1'b0; pre_en = 1'b0;
        wait_cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_chain_ctrl.md
Name: counter_chain_ctrl

Overview:
- Sequences a chain of NUM_DIGITS cascaded 4-bit up/down digit counters for the display/timer datapath.
- Owns the count-rate prescaler, the run/pause/clear state machine, the shared count direction, and the per-digit enables for ripple carry and borrow.
- Reads back the digit values to decide which digits step on each tick and to detect the all-ones or all-zeros limit.
- Sits between debounced pushbutton pulses and the digit counter instances.

Parameters:
- NUM_DIGITS, 4: number of cascaded digit counters; digit 0 is least significant.
- TICK_DIV, 100000000: clock cycles per count step; must be >= 2.
- STOP_AT_LIMIT, 1: 1 = halt at the limit (0xF..F up, 0x0..0 down); 0 = wrap freely.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- start_stop  input  1  single-cycle pulse; toggles run/pause.
- dir_toggle  input  1  single-cycle pulse; inverts count direction.
- clear  input  1  single-cycle pulse; zeroes all digits and returns to IDLE.
- digits_in  input  4*NUM_DIGITS  current digit values; digit i is bits [4i+3:4i].
- digit_en  output  NUM_DIGITS  per-digit count enable, one-cycle pulses.
- count_dir  output  1  shared direction to all digits; 1 = up, 0 = down.
- digit_rst  output  1  synchronous clear to all digit counters.
- running  output  1  high while in RUN.
- at_limit  output  1  high while in DONE.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, prescaler 0, digit_en 0, count_dir 1, digit_rst 1, running 0, at_limit 0.
- digit_rst is 1 in the cycle after any reset or clear cycle, otherwise 0.
- States: IDLE, RUN, PAUSED, DONE.
  - IDLE, start_stop -> RUN.
  - RUN, start_stop -> PAUSED.
  - PAUSED, start_stop -> RUN.
  - DONE ignores start_stop.
  - DONE, dir_toggle -> PAUSED, with direction inverted.
  - clear -> IDLE from any state.
- Event priority in one cycle: reset > clear > start_stop > dir_toggle.
  - clear together with start_stop: go to IDLE; start_stop is dropped.
  - start_stop together with dir_toggle: both take effect in that cycle.
- Direction:
  - dir_toggle inverts count_dir in any state; the output updates on the next edge.
  - A toggle that lands on a tick cycle applies to the following tick, not the current one.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - Held at 0 in every other state, so the first tick after entering RUN comes exactly TICK_DIV cycles later.
  - A tick occurs in the cycle where the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
- Enable generation, evaluated with digits_in sampled in the tick cycle:
  - digit_en[0] = 1.
  - digit_en[i] = 1 iff every digit j<i is terminal.
  - Terminal means 0xF when counting up and 0x0 when counting down.
  - digit_en is driven on the edge following the tick cycle, high for exactly one cycle; 0 in all other cycles.
- Limit:
  - With STOP_AT_LIMIT=1, a tick where all digits are terminal issues no enables and moves to DONE; at_limit=1 from the next edge.
  - With STOP_AT_LIMIT=0, all enables fire and the chain wraps, e.g. 0xFF -> 0x00 up, 0x00 -> 0xFF down.
- Pause: start_stop on a tick cycle still issues that tick's enables, then the block enters PAUSED.
- Reset or clear mid-operation aborts any pending enable; digit_en is 0 on the next edge.
- running = (state==RUN); at_limit = (state==DONE).

Test Plan:
All scenarios use NUM_DIGITS=2, TICK_DIV=4 unless stated; the bench models the digit counters.

1. Reset, then start_stop:
   - digit_rst=1 for one cycle after reset.
   - First digit_en=2'b01 exactly 4 cycles after RUN entry, then every 4 cycles.
   - Digits read 0x01, 0x02 and so on.
2. Carry and borrow:
   - Preload via model to 0x0F, count up: next tick gives digit_en=2'b11, digits 0x10.
   - From 0x10 counting down: digit_en=2'b11, digits 0x0F.
3. Limit, STOP_AT_LIMIT=1:
   - From 0xFE counting up: one tick gives 0xFF, next tick gives no enable, at_limit=1, running=0.
   - start_stop is ignored.
   - dir_toggle gives PAUSED with count_dir=0; start_stop then counts down to 0xFE.
4. Wrap, STOP_AT_LIMIT=0: from 0xFF counting up, tick gives digit_en=2'b11, digits 0x00, at_limit stays 0.
5. Simultaneous clear+start_stop in RUN: IDLE, running=0, digit_rst=1 for one cycle, no digit_en.
6. Pause/resume:
   - start_stop 2 cycles into a tick period gives PAUSED with the prescaler held at 0.
   - Resume gives the next digit_en exactly 4 cycles later.
   - A reset asserted mid-RUN forces all reset values on the next edge.
